// File: rtl/cdc_handshake_tx_if.sv
// Word-level bus of the source half of a 4-phase req/ack CDC link.
// The master side is the transmitter; the slave side is its upstream and destination environment.
interface cdc_handshake_tx_if #(
   parameter int LOGIC_SIZE = 8
);
   logic                  i_valid;
   logic [LOGIC_SIZE-1:0] i_data;
   logic                  o_ready;
   logic                  o_req;
   logic [LOGIC_SIZE-1:0] o_data;
   logic                  i_ack;

   modport master (
      input  i_valid,
      input  i_data,
      input  i_ack,
      output o_ready,
      output o_req,
      output o_data
   );

   modport slave (
      output i_valid,
      output i_data,
      output i_ack,
      input  o_ready,
      input  o_req,
      input  o_data
   );
endinterface

// File: rtl/cdc_handshake_tx.sv
// Source-domain half of a 4-phase req/ack link: captures one word, raises o_req,
// and holds o_data until the synchronized ack has completed a full request/release cycle.
module cdc_handshake_tx #(
   parameter int LOGIC_SIZE     = 8,
   parameter int NUM_FFS        = 2,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int CNT_WIDTH      = 16
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   cdc_handshake_tx_if.master   bus,
   output logic                 o_busy,
   output logic [CNT_WIDTH-1:0] o_xfer_count,
   output logic                 o_timeout,
   input  logic                 i_clear_timeout
);

   localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DROP
   } state_t;

   state_t                state_q,   state_d;
   logic                  req_q,     req_d;
   logic [LOGIC_SIZE-1:0] data_q,    data_d;
   logic [CNT_WIDTH-1:0]  cnt_q,     cnt_d;
   logic                  timeout_q, timeout_d;
   logic [TW-1:0]         tcnt_q,    tcnt_d;
   logic [NUM_FFS-1:0]    sync_q,    sync_d;
   logic                  ack_sync;

   // i_ack is only ever consumed through the last stage of this chain.
   assign ack_sync = sync_q[NUM_FFS-1];

   always_comb begin
      sync_d = {sync_q[NUM_FFS-2:0], bus.i_ack};
   end

   always_comb begin
      // NOTE: every _d starts from its _q so no branch can leave a value unassigned (no latch).
      state_d = state_q;
      req_d   = req_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (bus.i_valid && !ack_sync) begin
               data_d  = bus.i_data;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (ack_sync) begin
               req_d   = 1'b0;
               cnt_d   = cnt_q + 1'b1;
               state_d = DROP;
            end
         end
         DROP: begin
            if (!ack_sync) state_d = IDLE;
         end
         default: begin
            req_d   = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timeout
         localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
         localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_CYCLES);

         // Saturating one past T_LAST makes the timeout event fire once per stalled state.
         always_comb begin
            tcnt_d = '0;
            if ((state_q != IDLE) && (state_d == state_q)) begin
               tcnt_d = (tcnt_q == T_MAX) ? tcnt_q : tcnt_q + 1'b1;
            end
            timeout_d = (timeout_q && !i_clear_timeout) ||
                        ((state_q != IDLE) && (tcnt_q == T_LAST));
         end
      end else begin : g_no_timeout
         always_comb begin
            tcnt_d    = '0;
            timeout_d = 1'b0;
         end
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      // NOTE: state registers take non-blocking assignments so every flop samples pre-edge values.
      if (i_reset) begin
         state_q   <= IDLE;
         req_q     <= 1'b0;
         data_q    <= '0;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         tcnt_q    <= '0;
         sync_q    <= '0;
      end else begin
         state_q   <= state_d;
         req_q     <= req_d;
         data_q    <= data_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         tcnt_q    <= tcnt_d;
         sync_q    <= sync_d;
      end
   end

   assign bus.o_ready   = (state_q == IDLE) && !ack_sync;
   assign bus.o_req     = req_q;
   assign bus.o_data    = data_q;
   assign o_busy        = (state_q != IDLE);
   assign o_xfer_count  = cnt_q;
   assign o_timeout     = timeout_q;

endmodule
